// File: rtl/iob_vexriscv_dbus_bridge.sv
// Bridges the VexRiscv data-bus command/response port onto the IOb native bus.
// Define IOB_DBUS_MISALIGN_TRAP_EN to answer misaligned half/word accesses with an error.
module iob_vexriscv_dbus_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [1:0]          cmd_size,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  output logic                rsp_error,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata
);

`ifdef IOB_DBUS_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // The timer value seen in the last BUSY cycle before it would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = ~TIMEOUT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] timer;
  logic [3:0]           size_mask;
  logic [6:0]           strobe_wide;
  logic [3:0]           next_wstrb;
  logic [DATA_W-1:0]    next_wdata;
  logic                 misaligned;
  logic                 accept;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    size_mask  = 4'h0;
    next_wdata = cmd_data;
    case (cmd_size)
      2'd0: begin
        size_mask  = 4'h1;
        next_wdata = {4{cmd_data[7:0]}};
      end
      2'd1: begin
        size_mask  = 4'h3;
        next_wdata = {2{cmd_data[15:0]}};
      end
      2'd2: size_mask = 4'hF;
      default: size_mask = 4'h0;
    endcase
    // Misaligned strobes simply fall off the top lane when not trapped.
    strobe_wide = {3'b000, size_mask} << cmd_address[1:0];
    next_wstrb  = cmd_wr ? strobe_wide[3:0] : 4'h0;
    misaligned  = ((cmd_size == 2'd1) && cmd_address[0]) ||
                  ((cmd_size == 2'd2) && (cmd_address[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      m_valid   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          if (accept) begin
            m_address <= cmd_address;
            m_wdata   <= next_wdata;
            m_wstrb   <= next_wstrb;
            timer     <= '0;
            if (TRAP_EN && misaligned) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_data  <= '0;
              state     <= RESP;
            end else begin
              m_valid <= 1'b1;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // A zero strobe means read semantics, including size 3 writes.
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_wstrb == '0) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b0;
              rsp_data  <= m_rdata;
              state     <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (timer == TIMER_LAST) begin
            m_valid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_data  <= '0;
            state     <= RESP;
          end else begin
            timer <= timer + TIMEOUT_W'(1);
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_vexriscv_dbus_bridge.sv
// Directed self-checking bench for iob_vexriscv_dbus_bridge (TIMEOUT_W=4).
module tb_iob_vexriscv_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_address;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_data;
  logic        m_valid;
  logic [31:0] m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles;

  iob_vexriscv_dbus_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr),
    .cmd_size(cmd_size),
    .cmd_address(cmd_address),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_error(rsp_error),
    .rsp_data(rsp_data),
    .m_valid(m_valid),
    .m_address(m_address),
    .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_ready(m_ready),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] data);
    cmd_valid   = valid;
    cmd_wr      = wr;
    cmd_size    = size;
    cmd_address = addr;
    cmd_data    = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst     = 1'b1;
    m_ready = 1'b0;
    m_rdata = '0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("rst_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    checkOutput("rst_m_address", m_address, 32'd0);
    checkOutput("rst_m_wdata", m_wdata, 32'd0);
    checkOutput("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);

    rst = 1'b0;
    tick();
    checkOutput("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Word read at 0x100, completed on the third BUSY cycle.
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checkOutput("rd_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("rd_m_address", m_address, 32'h100);
    checkOutput("rd_m_wstrb", {28'b0, m_wstrb}, 32'h0);
    checkOutput("rd_cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
    tick();
    checkOutput("rd_m_valid_hold", {31'b0, m_valid}, 32'd1);
    tick();
    m_ready = 1'b1;
    m_rdata = 32'hDEADBEEF;
    tick();
    m_ready = 1'b0;
    m_rdata = 32'h0;
    checkOutput("rd_m_valid_drop", {31'b0, m_valid}, 32'd0);
    checkOutput("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("rd_rsp_error", {31'b0, rsp_error}, 32'd0);
    checkOutput("rd_rsp_data", rsp_data, 32'hDEADBEEF);
    checkOutput("rd_cmd_ready_resp", {31'b0, cmd_ready}, 32'd0);
    tick();
    checkOutput("rd_rsp_valid_end", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rd_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);

    // Byte write 0xA5 to 0x203.
    applyStimulus(1'b1, 1'b1, 2'd0, 32'h203, 32'h000000A5);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checkOutput("bw_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("bw_m_address", m_address, 32'h203);
    checkOutput("bw_m_wstrb", {28'b0, m_wstrb}, 32'h8);
    checkOutput("bw_m_wdata", m_wdata, 32'hA5A5A5A5);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("bw_m_valid_drop", {31'b0, m_valid}, 32'd0);
    checkOutput("bw_no_rsp", {31'b0, rsp_valid}, 32'd0);
    checkOutput("bw_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Read that never completes: 15 BUSY cycles, then an error pulse.
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h300, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    busy_cycles = 0;
    while (m_valid && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
    checkOutput("to_busy_cycles", busy_cycles, 32'd15);
    checkOutput("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("to_rsp_error", {31'b0, rsp_error}, 32'd1);
    checkOutput("to_rsp_data", rsp_data, 32'd0);
    tick();
    checkOutput("to_rsp_valid_end", {31'b0, rsp_valid}, 32'd0);

    // m_ready on the final BUSY cycle wins over the timeout.
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h400, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("pri_m_valid", {31'b0, m_valid}, 32'd1);
    m_ready = 1'b1;
    m_rdata = 32'h12345678;
    tick();
    m_ready = 1'b0;
    m_rdata = 32'h0;
    checkOutput("pri_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("pri_rsp_error", {31'b0, rsp_error}, 32'd0);
    checkOutput("pri_rsp_data", rsp_data, 32'h12345678);
    tick();

    // Aligned half write to 0x102.
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h102, 32'h0000BEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checkOutput("hw_m_wstrb", {28'b0, m_wstrb}, 32'hC);
    checkOutput("hw_m_wdata", m_wdata, 32'hBEEFBEEF);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // Misaligned half write to 0x101.
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h101, 32'h00001234);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
`ifdef IOB_DBUS_MISALIGN_TRAP_EN
    checkOutput("mis_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("mis_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("mis_rsp_error", {31'b0, rsp_error}, 32'd1);
    tick();
    checkOutput("mis_rsp_valid_end", {31'b0, rsp_valid}, 32'd0);
    checkOutput("mis_cmd_ready", {31'b0, cmd_ready}, 32'd1);
`else
    checkOutput("mis_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("mis_m_wstrb", {28'b0, m_wstrb}, 32'h6);
    checkOutput("mis_m_wdata", m_wdata, 32'h12341234);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("mis_no_rsp", {31'b0, rsp_valid}, 32'd0);
`endif

    // Size 3 write behaves as a read with no error.
    applyStimulus(1'b1, 1'b1, 2'd3, 32'h500, 32'hFFFFFFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checkOutput("s3_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("s3_m_wstrb", {28'b0, m_wstrb}, 32'h0);
    m_ready = 1'b1;
    m_rdata = 32'hCAFEF00D;
    tick();
    m_ready = 1'b0;
    m_rdata = 32'h0;
    checkOutput("s3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("s3_rsp_error", {31'b0, rsp_error}, 32'd0);
    checkOutput("s3_rsp_data", rsp_data, 32'hCAFEF00D);
    tick();

    // Stray m_ready while idle.
    m_ready = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    tick();
    m_ready = 1'b0;
    m_rdata = 32'h0;
    checkOutput("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("stray_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("stray_rsp_data", rsp_data, 32'hCAFEF00D);

    // Reset in the middle of a read, then a fresh word write.
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h600, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checkOutput("mr_m_valid_busy", {31'b0, m_valid}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mr_m_valid", {31'b0, m_valid}, 32'd0);
    checkOutput("mr_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("mr_m_address", m_address, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("mr_no_rsp", {31'b0, rsp_valid}, 32'd0);
    checkOutput("mr_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h700, 32'h11223344);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    checkOutput("mr_next_m_valid", {31'b0, m_valid}, 32'd1);
    checkOutput("mr_next_m_wstrb", {28'b0, m_wstrb}, 32'hF);
    checkOutput("mr_next_m_wdata", m_wdata, 32'h11223344);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checkOutput("mr_next_done", {31'b0, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
